// File: rtl/key_schedule_engine_if.sv
// -----------------------------------------------------------------------------
// key_schedule_engine_if
//
// Purpose: groups the request/response signals of the AES key-schedule engine.
// The engine is the slave and the round-datapath side is the master.
//
// Signals:
//   start      master->slave  request expansion of key_in (sampled in IDLE only)
//   key_in     master->slave  cipher key, 32*NK bits, word 0 in the MSBs
//   busy       slave->master  high while an expansion is in progress
//   done       slave->master  one-cycle pulse at the end of an expansion
//   word_valid slave->master  a schedule word was written this cycle
//   word_idx   slave->master  index of that word
//   word_out   slave->master  value of that word
//   schedule   slave->master  full schedule, word 0 in the MSBs
//   dbg_state  slave->master  FSM state, for observation only
// -----------------------------------------------------------------------------
interface key_schedule_engine_if #(
    parameter int NK = 4,
    parameter int NR = 10
);
    logic                    start;
    logic [32*NK-1:0]        key_in;
    logic                    busy;
    logic                    done;
    logic                    word_valid;
    logic [5:0]              word_idx;
    logic [31:0]             word_out;
    logic [128*(NR+1)-1:0]   schedule;
    logic [1:0]              dbg_state;

    modport master (
        output start, key_in,
        input  busy, done, word_valid, word_idx, word_out, schedule, dbg_state
    );

    modport slave (
        input  start, key_in,
        output busy, done, word_valid, word_idx, word_out, schedule, dbg_state
    );
endinterface

// File: rtl/key_schedule_engine.sv
// -----------------------------------------------------------------------------
// key_schedule_engine
//
// Purpose: iterative AES key expansion (AES-128/192/256 via NK/NR). After a
// one-cycle load of the cipher key, one 32-bit schedule word is produced per
// clock. The whole schedule is kept in a register and presented flat on
// bus.schedule, word 0 in the MSBs.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts any expansion in progress
//   bus    key_schedule_engine_if.slave (start/key_in in; busy, done,
//          word_valid, word_idx, word_out, schedule, dbg_state out)
//
// Handshake: start is a level request that is only looked at in IDLE; it is
// accepted on the edge that loads key_in, after which busy is high until the
// FINISH edge. Any start seen while busy or in FINISH is dropped, not queued.
// done pulses for one cycle after the FINISH edge; word_valid qualifies
// word_idx/word_out for exactly the cycle following each word write.
// -----------------------------------------------------------------------------

// Combinational AES S-box (forward), table lookup.
module key_schedule_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset is (255 - in_byte) * 8.
    assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];
endmodule

module key_schedule_engine #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    key_schedule_engine_if.slave  bus
);
    localparam int NW    = 4 * (NR + 1);
    localparam int SW    = 32 * NW;
    localparam int TAILW = 32 * (NW - NK);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [0:NW-1][31:0]  words_q, words_d;
    logic [SW-1:0]        words_flat;
    logic [7:0]           rcon_q, rcon_d;
    logic [5:0]           i_q, i_d;
    // j tracks i mod NK so no divider is needed for AES-192.
    logic [2:0]           j_q, j_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wv_q, wv_d;
    logic [5:0]           idx_q, idx_d;
    logic [31:0]          out_q, out_d;

    logic [31:0]          prev_word;
    logic [31:0]          back_word;
    logic [31:0]          sub_word;
    logic [31:0]          temp;
    logic [31:0]          new_word;

    assign words_flat = words_q;

    // w[i-1] and w[i-NK] are only meaningful while expanding; elsewhere i may
    // lie outside the schedule, so the reads are gated to keep them in range.
    always_comb begin
        prev_word = '0;
        back_word = '0;
        if (state_q == ST_EXPAND) begin
            prev_word = words_q[i_q - 6'd1];
            back_word = words_q[i_q - 6'(NK)];
        end
    end

    // SubWord on the un-rotated word; RotWord is applied afterwards since the
    // byte-wise S-box commutes with a byte rotation.
    key_schedule_sbox u_sbox0 (.in_byte(prev_word[31:24]), .out_byte(sub_word[31:24]));
    key_schedule_sbox u_sbox1 (.in_byte(prev_word[23:16]), .out_byte(sub_word[23:16]));
    key_schedule_sbox u_sbox2 (.in_byte(prev_word[15:8]),  .out_byte(sub_word[15:8]));
    key_schedule_sbox u_sbox3 (.in_byte(prev_word[7:0]),   .out_byte(sub_word[7:0]));

    always_comb begin
        state_d  = state_q;
        words_d  = words_q;
        rcon_d   = rcon_q;
        i_d      = i_q;
        j_d      = j_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wv_d     = 1'b0;
        idx_d    = idx_q;
        out_d    = out_q;
        temp     = prev_word;
        new_word = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Key goes into words 0..NK-1; later words keep old values.
                    words_d = {bus.key_in, words_flat[TAILW-1:0]};
                    i_d     = 6'(NK);
                    j_d     = 3'd0;
                    busy_d  = 1'b1;
                    state_d = ST_EXPAND;
                end
            end

            ST_EXPAND: begin
                if (j_q == 3'd0) begin
                    temp   = {sub_word[23:0], sub_word[31:24]} ^ {rcon_q, 24'h0};
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end else if (NK == 8 && j_q == 3'd4) begin
                    temp = sub_word;
                end
                new_word      = back_word ^ temp;
                words_d[i_q]  = new_word;
                wv_d          = 1'b1;
                idx_d         = i_q;
                out_d         = new_word;
                i_d           = i_q + 6'd1;
                j_d           = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
                if (i_q == 6'(NW - 1)) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                rcon_d  = 8'h01;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            rcon_q  <= 8'h01;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wv_q    <= 1'b0;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            rcon_q  <= rcon_d;
            i_q     <= i_d;
            j_q     <= j_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wv_q    <= wv_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.word_valid = wv_q;
    assign bus.word_idx   = idx_q;
    assign bus.word_out   = out_q;
    assign bus.schedule   = words_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: doc/key_schedule_engine.md
Name: key_schedule_engine

Overview:
- Iterative AES key-expansion stage that sits directly upstream of the encrypt/decrypt round datapaths.
- Replaces the combinational expansion with a sequential engine that generates one 32-bit schedule word per clock from a loaded cipher key.
- The full schedule is held in an internal register and presented flat on `schedule`, in the same layout the round datapaths consume: word 0 in the MSBs, big-endian bit order.
- One parameterised module covers AES-128/192/256.

Parameters:
- NK, 4, key length in 32-bit words (4, 6 or 8).
- NR, 10, number of rounds (10, 12 or 14; always NK+6).
- NW, 4*(NR+1), total schedule words (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request expansion of key_in; sampled only in IDLE.
- key_in  input  32*NK  cipher key, word 0 in the MSBs.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when the last word is written.
- word_valid  output  1  high on each cycle a new schedule word is written.
- word_idx  output  6  index of the word written this cycle.
- word_out  output  32  value of the word written this cycle.
- schedule  output  128*(NR+1)  full key schedule, word i at bits [32*i +: 32] counted from the MSB end.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, word_valid = 0; word_idx, word_out = 0.
  - schedule all zero; rcon=8'h01; counter i=0.
  - Asserting reset mid-expansion aborts the expansion; no done pulse is produced.
- States: IDLE, EXPAND, FINISH.
- IDLE:
  - On a clock edge with start=1, write key_in into words 0..NK-1 in one cycle.
  - Set i=NK, busy=1 and go to EXPAND.
  - word_valid stays 0 on the load cycle.
- EXPAND: each edge computes w[i] from temp=w[i-1] and writes it:
  - if i mod NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon), with the reduction ^8'h1b applied when bit 7 is set.
  - else if NK==8 and i mod 8==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - word_valid=1, word_idx=i, word_out=w[i]; then i=i+1.
  - When i==NW-1 is written, go to FINISH.
- FINISH (one cycle):
  - done=1, busy=0, word_valid=0; return to IDLE.
  - rcon resets to 8'h01 for the next run.
- Latency:
  - Start is sampled at edge t0; word NK is written at t1.
  - Word NW-1 is written at t(NW-NK).
  - done is high for one cycle after edge t(NW-NK+1): t41 for AES-128, t47 for AES-192, t53 for AES-256.
- start while busy or in FINISH is ignored.
- key_in is sampled only at the load edge; later changes have no effect on the run.
- schedule holds its value until the next load. During an expansion, words not yet written keep their previous-run values; the consumer must wait for done.
- SubWord uses four instances of the team's existing combinational S-box. It adds no pipeline stage.
- A new start after done restarts the expansion from a fresh key.

Test Plan:
- NK=4, NR=10, key_in=000102030405060708090a0b0c0d0e0f, start pulse:
  - first word_valid shows word_idx=4, word_out=d6aa74fd.
  - done 41 cycles after start.
  - schedule words 40..43 = 13111d7f e3944a17 f307a78b 4d2b30c5.
- NK=6, NR=12, key_in=000102…1617:
  - done at cycle 47.
  - last round key (words 48..51) = a4970a33 1a78dc09 c418c271 e3a41d5d.
- NK=8, NR=14, key_in=000102…1e1f:
  - done at cycle 53.
  - last round key = 24fc79cc bf0979e9 371ac23c 6d68de36.
  - exercises the i mod 8==4 SubWord path.
- Start held high for 10 cycles during a NK=4 run:
  - exactly one expansion runs; word_idx increments 4..43 with no gaps.
  - exactly one done pulse.
- Reset asserted at cycle 20 of a run:
  - busy, done, word_valid and schedule clear immediately, asynchronously to clk.
  - a fresh start then yields the same results as the first scenario.
- Back-to-back runs:
  - done, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - words 40..43 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, confirming rcon restarts at 01.
